bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/sat_counter.sv | 27 ++
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the CPU/DMA bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    CPU_OWN   = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_t;

  localparam int DEF_MAX_BURST    = 4;
  localparam int DEF_STARVE_LIMIT = 8;

  // Bits needed to hold every value from 0 up to and including limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at LIMIT; clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  assign sat = (count == WIDTH'(LIMIT));

  // Count register: async clear on reset, sync clear, saturating increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-port memory arbiter between a CPU MEM stage and a bursting DMA engine.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int BEAT_W   = cnt_width(MAX_BURST - 1);
  localparam int STARVE_W = cnt_width(STARVE_LIMIT);

  arb_state_t state, next_state;

  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_sat;
  logic                starve_last;
  logic                starve_inc, starve_clr;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                beat_sat;
  logic                beat_inc, beat_clr;
  logic                dma_read_beat;
  logic                unused_beat_bits;

  // The burst length is tracked through the saturation flag alone.
  assign unused_beat_bits = ^beat_cnt;

  // A contention cycle won by the CPU at count LIMIT-1 is its last win;
  // DMA takes the bus at the following edge.
  assign starve_last = (starve_cnt == STARVE_W'(STARVE_LIMIT - 1));

  assign starve_inc = (state == CPU_OWN) && cpu_req && dma_req;
  assign starve_clr = !dma_req || (next_state == DMA_BURST);
  assign beat_inc   = (state == DMA_BURST) && dma_req;
  assign beat_clr   = (next_state == CPU_OWN);

  assign dma_read_beat = (state == DMA_BURST) && dma_req && !dma_wr;

  sat_counter #(
    .WIDTH (STARVE_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .count (starve_cnt),
    .sat   (starve_sat)
  );

  sat_counter #(
    .WIDTH (BEAT_W),
    .LIMIT (MAX_BURST - 1)
  ) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (beat_inc),
    .clr   (beat_clr),
    .count (beat_cnt),
    .sat   (beat_sat)
  );

  // Bus owner register; reset hands the bus back to the CPU immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CPU_OWN;
    end else begin
      state <= next_state;
    end
  end

  // Ownership decision: DMA enters when the CPU is idle or starving it,
  // leaves after its last beat or as soon as it stops requesting.
  always_comb begin
    next_state = state;
    unique case (state)
      CPU_OWN: begin
        if (dma_req && (!cpu_req || starve_sat || starve_last)) begin
          next_state = DMA_BURST;
        end
      end
      DMA_BURST: begin
        if (!dma_req || beat_sat) begin
          next_state = CPU_OWN;
        end
      end
    endcase
  end

  // Memory mux and handshake outputs; everything is held at 0 during reset.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    dma_gnt   = 1'b0;
    if (reset) begin
      unique case (state)
        CPU_OWN: begin
          if (cpu_req) begin
            mem_rd    = !cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
          end
        end
        DMA_BURST: begin
          cpu_stall = cpu_req;
          dma_gnt   = dma_req;
          if (dma_req) begin
            mem_rd    = !dma_wr;
            mem_wr    = dma_wr;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
          end
        end
      endcase
    end
  end

  // DMA read return path: capture the beat's data and flag it for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_read_beat;
      if (dma_read_beat) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule
